// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction-memory arbiter.
//   IMEM_ADDR_W / INSTR_W : default instruction RAM geometry (64 x 32)
//   arb_state_t           : arbiter FSM encoding (RUN / HALT)
//   `IMEM_WORD_IDX        : byte PC -> RAM word index (drops bits [1:0])
`ifndef CPU_PKG_SV
`define CPU_PKG_SV

`define IMEM_WORD_IDX(pa, aw) pa[(aw)+1:2]

package cpu_pkg;
    localparam int IMEM_ADDR_W = 6;
    localparam int INSTR_W     = 32;

    typedef enum logic {
        ARB_RUN  = 1'b0,
        ARB_HALT = 1'b1
    } arb_state_t;
endpackage

`endif

// File: rtl/imem_fair_counter.sv
// Starvation guard for the debug port.
// Counts fetch grants that happen while a debug request is waiting; once the
// count reaches DBG_WAIT_MAX, force_dbg tells the arbiter to let debug win
// the next contested cycle.
//   clk, rst   : clock, synchronous active-high reset
//   fetch_gnt  : fetch granted this cycle
//   dbg_gnt    : debug granted this cycle
//   dbg_req    : debug request pending this cycle
//   force_dbg  : wait count has reached DBG_WAIT_MAX
module imem_fair_counter
    import cpu_pkg::*;
#(
    parameter int DBG_WAIT_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_gnt,
    input  logic dbg_gnt,
    input  logic dbg_req,
    output logic force_dbg
);
    localparam logic [3:0] WAIT_MAX = 4'(DBG_WAIT_MAX);

    logic [3:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if (dbg_gnt || !dbg_req) begin
            r_wait_cnt <= 4'd0;
        end else if (fetch_gnt && (r_wait_cnt != WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign force_dbg = (r_wait_cnt == WAIT_MAX);
endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction RAM between CPU fetch and the
// debug/loader port. Fetch has default priority; a waiting debug request is
// forced through after DBG_WAIT_MAX fetch grants. dbg_halt keeps fetch off
// the RAM from the very cycle it is raised.
//   fetch_*   : CPU fetch request / stall / registered ack + instruction
//   dbg_*     : debug request, registered ack + read data, halt level
//   halted    : registered HALT state flag
//   dbg_wr_cnt: completed debug writes (wrapping)
//   ram_*     : drive of the asynchronous-read RAM primitive
module imem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int DATA_W       = INSTR_W,
    parameter int DBG_WAIT_MAX = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pa,
    output logic              fetch_stall,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rd,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_halt,
    output logic              halted,
    output logic [CNT_W-1:0]  dbg_wr_cnt,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_spo
);
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_fetch_gnt;
    logic              w_dbg_gnt;
    logic              w_force_dbg;
    logic [ADDR_W-1:0] w_fetch_idx;

    logic              r_fetch_ack;
    logic [DATA_W-1:0] r_fetch_rd;
    logic              r_dbg_ack;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic [CNT_W-1:0]  r_dbg_wr_cnt;

    // Only bits [ADDR_W+1:2] of the byte PC address the RAM.
    logic w_unused_pa_bits;
    assign w_unused_pa_bits = ^{fetch_pa[31:ADDR_W+2], fetch_pa[1:0]};

    assign w_fetch_idx = `IMEM_WORD_IDX(fetch_pa, ADDR_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The next state also gates fetch in the current cycle, so entering HALT
    // blocks fetch immediately and leaving HALT re-enables it immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch_gnt = 1'b0;
        w_dbg_gnt   = 1'b0;
        case (r_state)
            ARB_RUN:  if (dbg_halt)  w_state_nxt = ARB_HALT;
            ARB_HALT: if (!dbg_halt) w_state_nxt = ARB_RUN;
            default:  w_state_nxt = ARB_RUN;
        endcase
        if (w_state_nxt == ARB_RUN) begin
            w_dbg_gnt   = dbg_req && (!fetch_req || w_force_dbg);
            w_fetch_gnt = fetch_req && !w_dbg_gnt;
        end else begin
            w_dbg_gnt   = dbg_req;
        end
    end

    imem_fair_counter #(
        .DBG_WAIT_MAX (DBG_WAIT_MAX)
    ) u_fair (
        .clk       (clk),
        .rst       (rst),
        .fetch_gnt (w_fetch_gnt),
        .dbg_gnt   (w_dbg_gnt),
        .dbg_req   (dbg_req),
        .force_dbg (w_force_dbg)
    );

    assign fetch_stall = fetch_req && !w_fetch_gnt;
    assign ram_a       = w_dbg_gnt ? dbg_addr : w_fetch_idx;
    assign ram_d       = dbg_wdata;
    // A write granted during reset must not reach the RAM.
    assign ram_we      = w_dbg_gnt && dbg_we && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_ack  <= 1'b0;
            r_fetch_rd   <= '0;
            r_dbg_ack    <= 1'b0;
            r_dbg_rdata  <= '0;
            r_dbg_wr_cnt <= '0;
        end else begin
            r_fetch_ack <= w_fetch_gnt;
            r_dbg_ack   <= w_dbg_gnt;
            if (w_fetch_gnt) r_fetch_rd <= ram_spo;
            // ram_spo still shows the old word at the write edge.
            if (w_dbg_gnt)   r_dbg_rdata <= ram_spo;
            if (w_dbg_gnt && dbg_we) r_dbg_wr_cnt <= r_dbg_wr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign fetch_ack  = r_fetch_ack;
    assign fetch_rd   = r_fetch_rd;
    assign dbg_ack    = r_dbg_ack;
    assign dbg_rdata  = r_dbg_rdata;
    assign dbg_wr_cnt = r_dbg_wr_cnt;
    assign halted     = (r_state == ARB_HALT);
endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int WMAX   = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic [31:0]       fetch_pa;
    logic              fetch_stall;
    logic              fetch_ack;
    logic [DATA_W-1:0] fetch_rd;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_halt;
    logic              halted;
    logic [CNT_W-1:0]  dbg_wr_cnt;
    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;
    logic              ram_we;
    logic [DATA_W-1:0] ram_spo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DBG_WAIT_MAX(WMAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pa(fetch_pa), .fetch_stall(fetch_stall),
        .fetch_ack(fetch_ack), .fetch_rd(fetch_rd),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .dbg_halt(dbg_halt), .halted(halted), .dbg_wr_cnt(dbg_wr_cnt),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo)
    );

    // RAM primitive: asynchronous read, synchronous write.
    logic [DATA_W-1:0] mem [64];
    assign ram_spo = mem[ram_a];
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image plus the expected registered outputs.
    logic [31:0] m_mem [64];
    bit          m_valid = 0;
    bit          m_fack, m_dack, m_halted;
    logic [31:0] m_frd, m_drd;
    int          m_cnt, m_wait;
    bit          e_elig, e_fwant, e_dg, e_fg;
    int          e_fidx;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("fetch_ack",  32'(fetch_ack),  32'(m_fack));
            chk("fetch_rd",   fetch_rd,        m_frd);
            chk("dbg_ack",    32'(dbg_ack),    32'(m_dack));
            chk("dbg_rdata",  dbg_rdata,       m_drd);
            chk("halted",     32'(halted),     32'(m_halted));
            chk("dbg_wr_cnt", 32'(dbg_wr_cnt), m_cnt % 65536);
        end
        e_fidx  = (fetch_pa / 4) % 64;
        e_elig  = !dbg_halt;
        e_fwant = fetch_req && e_elig;
        e_dg    = dbg_req && (!e_fwant || m_wait >= WMAX);
        e_fg    = e_fwant && !e_dg;
        if (m_valid) begin
            chk("fetch_stall", 32'(fetch_stall), 32'(fetch_req && !e_fg));
            chk("ram_we",      32'(ram_we),      32'(e_dg && dbg_we && !rst));
            chk("ram_a",       32'(ram_a),       e_dg ? 32'(dbg_addr) : e_fidx);
            chk("ram_d",       ram_d,            dbg_wdata);
        end
        if (rst) begin
            m_valid = 1; m_fack = 0; m_dack = 0; m_halted = 0;
            m_frd = 0; m_drd = 0; m_cnt = 0; m_wait = 0;
        end else begin
            m_fack = e_fg;
            m_dack = e_dg;
            if (e_fg) m_frd = m_mem[e_fidx];
            if (e_dg) begin
                m_drd = m_mem[dbg_addr];
                if (dbg_we) begin
                    m_mem[dbg_addr] = dbg_wdata;
                    m_cnt++;
                end
            end
            m_halted = dbg_halt;
            if (e_dg || !dbg_req) m_wait = 0;
            else if (e_fg) m_wait++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 0; fetch_pa = 0; dbg_req = 0; dbg_we = 0;
        dbg_addr = 0; dbg_wdata = 0; dbg_halt = 0;
    endtask

    logic [31:0] pa_tab [3];
    logic [31:0] rd_tab [3];
    bit          stall_tab [6];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]   = 32'h11111100 + 32'(i);
            m_mem[i] = 32'h11111100 + 32'(i);
        end
        mem[0] = 32'h00242820; m_mem[0] = 32'h00242820;
        mem[1] = 32'hac250004; m_mem[1] = 32'hac250004;
        mem[2] = 32'h8c260004; m_mem[2] = 32'h8c260004;
        pa_tab = '{32'h0, 32'h4, 32'h8};
        rd_tab = '{32'h00242820, 32'hac250004, 32'h8c260004};
        stall_tab = '{0, 0, 0, 0, 1, 0};

        rst = 1; idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset fetch_ack", 32'(fetch_ack), 32'h0);
        chk("reset dbg_wr_cnt", 32'(dbg_wr_cnt), 32'h0);
        chk("reset halted", 32'(halted), 32'h0);

        // Back-to-back fetches
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1; fetch_pa = pa_tab[i];
            #1 chk("seq fetch_stall", 32'(fetch_stall), 32'h0);
            tick();
            chk("seq fetch_ack", 32'(fetch_ack), 32'h1);
            chk("seq fetch_rd", fetch_rd, rd_tab[i]);
        end
        fetch_req = 0;
        tick();

        // Halt, debug write then read of word 0
        dbg_halt = 1; fetch_req = 1; fetch_pa = 0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'h20080000;
        #1 chk("halt fetch_stall", 32'(fetch_stall), 32'h1);
        tick();
        chk("halt halted", 32'(halted), 32'h1);
        chk("halt wr old word", dbg_rdata, 32'h00242820);
        chk("halt wr cnt", 32'(dbg_wr_cnt), 32'h1);
        dbg_we = 0;
        #1 chk("halt fetch_stall2", 32'(fetch_stall), 32'h1);
        tick();
        chk("halt rd new word", dbg_rdata, 32'h20080000);
        chk("halt no fetch ack", 32'(fetch_ack), 32'h0);
        idle();
        tick();

        // Contention: fetch wins WMAX times, then debug is forced through
        fetch_req = 1; fetch_pa = 32'h4; dbg_req = 1; dbg_we = 0; dbg_addr = 2;
        for (int i = 0; i < 6; i++) begin
            #1 chk("fair fetch_stall", 32'(fetch_stall), 32'(stall_tab[i]));
            tick();
            if (i == 4) begin
                chk("fair dbg_ack", 32'(dbg_ack), 32'h1);
                chk("fair dbg_rdata", dbg_rdata, 32'h8c260004);
                dbg_req = 0;
            end
        end
        idle();
        tick();

        // Write then immediate fetch of the same word
        dbg_req = 1; dbg_we = 1; dbg_addr = 5; dbg_wdata = 32'h08000011;
        tick();
        idle(); fetch_req = 1; fetch_pa = 32'h14;
        tick();
        chk("wr-then-fetch rd", fetch_rd, 32'h08000011);
        idle();
        tick();

        // Reset coinciding with a granted debug write
        rst = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 6; dbg_wdata = 32'hdeadbeef;
        #1 chk("rst ram_we", 32'(ram_we), 32'h0);
        tick();
        chk("rst dbg_ack", 32'(dbg_ack), 32'h0);
        chk("rst dbg_wr_cnt", 32'(dbg_wr_cnt), 32'h0);
        rst = 0; dbg_we = 0;
        tick();
        chk("rst word kept", dbg_rdata, 32'h11111106);
        idle();
        tick();

        // Address slicing: misaligned and out-of-range PCs
        fetch_req = 1; fetch_pa = 32'h7;
        #1 chk("misaligned ram_a", 32'(ram_a), 32'h1);
        tick();
        chk("misaligned rd", fetch_rd, 32'hac250004);
        fetch_pa = 32'h104;
        #1 chk("wrap ram_a", 32'(ram_a), 32'h1);
        tick();
        chk("wrap rd", fetch_rd, 32'hac250004);
        idle();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction RAM (64 x 32 distributed RAM, asynchronous read, synchronous write) between two requesters: CPU instruction fetch and the debug/loader port used to download programs and read memory back.
- Sits between the fetch stage / debug UART bridge and the RAM primitive.
- Provides a stall to the CPU, a CPU halt mode, and starvation-free arbitration.

Parameters:
- ADDR_W, 6: RAM word-address width (depth 2^ADDR_W).
- DATA_W, 32: instruction width.
- DBG_WAIT_MAX, 4: consecutive fetch grants allowed while a debug request waits before debug is forced through (range 1..15).
- CNT_W, 16: width of the debug write counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  CPU requests an instruction word this cycle.
- fetch_pa  in  32  byte PC; word index = fetch_pa[ADDR_W+1:2], bits [1:0] ignored.
- fetch_stall  out  1  combinational: fetch_req & ~fetch granted this cycle.
- fetch_ack  out  1  registered; retires the fetch granted last cycle.
- fetch_rd  out  DATA_W  registered instruction, valid with fetch_ack.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  word address.
- dbg_wdata  in  DATA_W  write data.
- dbg_ack  out  1  registered; retires the debug access granted last cycle.
- dbg_rdata  out  DATA_W  registered RAM word at dbg_addr before any write.
- dbg_halt  in  1  level: hold CPU fetch off the RAM.
- halted  out  1  registered; 1 while in HALT state.
- dbg_wr_cnt  out  CNT_W  number of completed debug writes.
- ram_a  out  ADDR_W  RAM address (combinational from winner).
- ram_d  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable (debug write granted only).
- ram_spo  in  DATA_W  RAM asynchronous read data.

Behaviour:
- Reset: state=RUN; fetch_ack=0, dbg_ack=0, fetch_rd=0, dbg_rdata=0, halted=0, dbg_wr_cnt=0, wait_cnt=0. Reset mid-access drops any pending ack; no RAM write occurs in the reset cycle (ram_we forced 0 while rst=1).
- Protocol: a request is sampled in cycle t with address/data stable. Its grant is decided combinationally in t. The granted side gets ack=1 in t+1 with data captured from ram_spo at the edge ending t. A requester not granted keeps req and addr stable until granted. req still high in t+1 is a new request, so 1 access per cycle is sustained.
- FSM states: RUN, HALT.
  - RUN -> HALT when dbg_halt=1, effective the same cycle: no fetch grant in that cycle.
  - HALT -> RUN when dbg_halt=0, with fetch eligible the same cycle.
  - halted is the registered state==HALT.
- Arbitration in RUN:
  - Default priority is fetch.
  - wait_cnt increments on each fetch grant while dbg_req=1 and resets to 0 on any debug grant or when dbg_req=0.
  - When wait_cnt==DBG_WAIT_MAX, debug wins the next contested cycle.
  - Uncontested requests are always granted.
- Arbitration in HALT: only debug is granted; fetch_stall = fetch_req.
- RAM drive:
  - ram_a = winner's word address.
  - ram_d = dbg_wdata.
  - ram_we = dbg granted & dbg_we.
  - With no grant, ram_a = fetch word index and ram_we=0.
- Debug write: dbg_rdata returns the old word (read-before-write). A fetch of that address in the following cycle returns the new word.
- dbg_wr_cnt increments on each granted write and wraps modulo 2^CNT_W.
- fetch_rd and dbg_rdata hold their value when not acked.

Decomposition:
- Shared package cpu_pkg holds:
  - localparams IMEM_ADDR_W=6 and INSTR_W=32;
  - state encoding ARB_RUN=1'b0, ARB_HALT=1'b1;
  - the fetch word-index slice helper macro for bits [ADDR_W+1:2].
- Natural sub-module: imem_fair_counter, the wait_cnt saturating counter with compare, producing force_dbg.
- Everything else stays in one module.

Test Plan:
- Reset, then fetch_req=1 with fetch_pa=0x0,0x4,0x8 on consecutive cycles, RAM preloaded 0x00242820, 0xac250004, 0x8c260004 -> fetch_ack=1 on cycles 2-4 with fetch_rd in that order; fetch_stall=0 throughout.
- dbg_halt=1; debug writes 0x20080000 to addr 0, then reads addr 0 -> halted=1 from the next cycle; fetch_stall=1; first dbg_rdata = old word; read returns 0x20080000; dbg_wr_cnt=1.
- DBG_WAIT_MAX=4, fetch_req and dbg_req both held high -> fetch granted 4 cycles, debug granted on the 5th (fetch_stall=1 that cycle only), then fetch resumes with wait_cnt=0.
- Debug write 0x08000011 to addr 5 in cycle t, fetch of 0x14 in t+1 -> fetch_rd=0x08000011 in t+2.
- rst asserted in the same cycle as a granted debug write -> ram_we=0, no ack next cycle, RAM word unchanged, dbg_wr_cnt=0.
- fetch_pa=0x7 (misaligned) -> word index 1 is read; fetch_pa=0x104 -> wraps to index 1 (bits above ADDR_W+1 ignored).
